// File: rtl/pwm_cmd_decoder.sv
// Packet command decoder for a bank of PWM channels: updates a shadow set per channel and
// commits it to the active set once the downstream generator for that channel is idle.
module pwm_cmd_decoder #(
    parameter int          _PAT_WIDTH = 16,
    parameter int          _CH_NUM    = 8,
    parameter logic [15:0] _WAIT_MAX  = 16'd50000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             recv_done,
    input  logic [7:0]                       dataA,
    input  logic [15:0]                      dataB,
    input  logic [15:0]                      dataC,
    input  logic [7:0]                       dataD,
    input  logic [_CH_NUM-1:0]               pwm_busy,
    output logic [_CH_NUM-1:0]               pwm_en,
    output logic [8*_CH_NUM-1:0]             duty_num,
    output logic [16*_CH_NUM-1:0]            pulse_dessert,
    output logic [8*_CH_NUM-1:0]             pulse_num,
    output logic [_PAT_WIDTH*_CH_NUM-1:0]    pat,
    output logic                             cmd_ack,
    output logic                             cmd_err,
    output logic [1:0]                       err_code
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WAIT, S_APPLY} state_t;

    localparam logic [3:0] OP_TIMING  = 4'h1;
    localparam logic [3:0] OP_PATTERN = 4'h2;
    localparam logic [3:0] OP_ENABLE  = 4'h3;
    localparam logic [3:0] OP_DISABLE = 4'h4;
    localparam logic [3:0] OP_COMMIT  = 4'h5;

    localparam logic [1:0] ERR_OPCODE  = 2'd0;
    localparam logic [1:0] ERR_CHANNEL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    state_t       state_q, state_d;
    logic [3:0]   opc_q;
    logic [2:0]   ch_q;
    logic [15:0]  b_q;
    logic [7:0]   c_q;
    logic [7:0]   d_q;
    logic [15:0]  cnt_q, cnt_d;

    logic         ack_q, err_q, ovr_q;
    logic [1:0]   code_q;

    logic [_CH_NUM-1:0]    en_q;
    logic [7:0]            sh_duty_q [_CH_NUM];
    logic [15:0]           sh_des_q  [_CH_NUM];
    logic [7:0]            sh_num_q  [_CH_NUM];
    logic [_PAT_WIDTH-1:0] sh_pat_q  [_CH_NUM];
    logic [7:0]            act_duty_q [_CH_NUM];
    logic [15:0]           act_des_q  [_CH_NUM];
    logic [7:0]            act_num_q  [_CH_NUM];
    logic [_PAT_WIDTH-1:0] act_pat_q  [_CH_NUM];

    logic       ch_ok, busy_sel, ovr_new;
    logic       done_ack, done_err, wr_timing, wr_pat, set_en, clr_en, load_act;
    logic [1:0] err_cause;

    // Reserved command bit and the upper byte of operand C carry no meaning.
    logic unused_bits;
    assign unused_bits = ^{dataA[3], dataC[15:8]};

    assign ch_ok   = (int'(ch_q) < _CH_NUM);
    assign ovr_new = recv_done && (state_q != S_IDLE);

    always_comb begin
        busy_sel = 1'b0;
        for (int k = 0; k < _CH_NUM; k++) begin
            if (ch_q == 3'(k)) busy_sel = pwm_busy[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (recv_done) state_d = S_DECODE;
            S_DECODE: begin
                if (!ch_ok || opc_q != OP_COMMIT) state_d = S_IDLE;
                else if (busy_sel)                state_d = S_WAIT;
                else                              state_d = S_APPLY;
            end
            S_WAIT: begin
                if (!busy_sel)                         state_d = S_APPLY;
                else if (cnt_q == _WAIT_MAX - 16'd1)   state_d = S_IDLE;
            end
            S_APPLY:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done_ack  = 1'b0;
        done_err  = 1'b0;
        err_cause = ERR_OPCODE;
        wr_timing = 1'b0;
        wr_pat    = 1'b0;
        set_en    = 1'b0;
        clr_en    = 1'b0;
        load_act  = 1'b0;
        cnt_d     = 16'd0;
        case (state_q)
            S_DECODE: begin
                if (!ch_ok) begin
                    done_err  = 1'b1;
                    err_cause = ERR_CHANNEL;
                end else begin
                    case (opc_q)
                        OP_TIMING:  begin wr_timing = 1'b1; done_ack = 1'b1; end
                        OP_PATTERN: begin wr_pat    = 1'b1; done_ack = 1'b1; end
                        OP_ENABLE:  begin set_en    = 1'b1; done_ack = 1'b1; end
                        OP_DISABLE: begin clr_en    = 1'b1; done_ack = 1'b1; end
                        OP_COMMIT:  load_act = !busy_sel;
                        default: begin
                            done_err  = 1'b1;
                            err_cause = ERR_OPCODE;
                        end
                    endcase
                end
            end
            S_WAIT: begin
                if (!busy_sel) begin
                    load_act = 1'b1;
                end else if (cnt_q == _WAIT_MAX - 16'd1) begin
                    done_err  = 1'b1;
                    err_cause = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_APPLY: done_ack = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
            opc_q <= 4'd0;
            ch_q  <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
            if (state_q == S_IDLE && recv_done) begin
                opc_q <= dataA[7:4];
                ch_q  <= dataA[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && recv_done) begin
            b_q <= dataB;
            c_q <= dataC[7:0];
            d_q <= dataD;
        end
    end

    // A completion owns the status strobe; a coinciding overrun is deferred one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            code_q <= 2'd0;
            ovr_q  <= 1'b0;
        end else begin
            ack_q <= done_ack;
            err_q <= 1'b0;
            if (done_ack) begin
                ovr_q <= ovr_q | ovr_new;
            end else if (done_err) begin
                err_q  <= 1'b1;
                code_q <= err_cause;
                ovr_q  <= ovr_q | ovr_new;
            end else if (ovr_q || ovr_new) begin
                err_q  <= 1'b1;
                code_q <= ERR_OVERRUN;
                ovr_q  <= ovr_q & ovr_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= '0;
            for (int k = 0; k < _CH_NUM; k++) begin
                sh_duty_q[k]  <= '0;
                sh_des_q[k]   <= '0;
                sh_num_q[k]   <= '0;
                sh_pat_q[k]   <= '0;
                act_duty_q[k] <= '0;
                act_des_q[k]  <= '0;
                act_num_q[k]  <= '0;
                act_pat_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < _CH_NUM; k++) begin
                if (ch_q == 3'(k)) begin
                    if (wr_timing) begin
                        sh_duty_q[k] <= d_q;
                        sh_des_q[k]  <= b_q;
                        sh_num_q[k]  <= c_q;
                    end
                    if (wr_pat) sh_pat_q[k] <= _PAT_WIDTH'(b_q);
                    if (set_en) en_q[k] <= 1'b1;
                    if (clr_en) en_q[k] <= 1'b0;
                    if (load_act) begin
                        act_duty_q[k] <= sh_duty_q[k];
                        act_des_q[k]  <= sh_des_q[k];
                        act_num_q[k]  <= sh_num_q[k];
                        act_pat_q[k]  <= sh_pat_q[k];
                    end
                end
            end
        end
    end

    // The channel being applied is held disabled for the APPLY cycle only.
    always_comb begin
        for (int k = 0; k < _CH_NUM; k++) begin
            duty_num[8*k +: 8]                 = act_duty_q[k];
            pulse_dessert[16*k +: 16]          = act_des_q[k];
            pulse_num[8*k +: 8]                = act_num_q[k];
            pat[_PAT_WIDTH*k +: _PAT_WIDTH]    = act_pat_q[k];
            pwm_en[k] = en_q[k] & ~((state_q == S_APPLY) && (ch_q == 3'(k)));
        end
    end

    assign cmd_ack  = ack_q;
    assign cmd_err  = err_q;
    assign err_code = code_q;

endmodule

// File: doc/pwm_cmd_decoder.md
PWM_CMD_DECODER -- requirements
Module: pwm_cmd_decoder

Interface
REQ-001 The block SHALL have parameter _PAT_WIDTH, default 16, giving the pattern register width per channel.
REQ-002 The block SHALL have parameter _CH_NUM, default 8, giving the number of PWM channels served (1..8).
REQ-003 The block SHALL have parameter _WAIT_MAX, default 16'd50000, giving the commit timeout in clk cycles.
REQ-004 clk  input  1  single clock; all logic is clocked on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 recv_done  input  1  one-cycle strobe; packet fields are valid in this cycle.
REQ-007 dataA  input  8  command byte: [7:4] opcode, [2:0] channel, [3] ignored.
REQ-008 dataB  input  16  operand B.
REQ-009 dataC  input  16  operand C.
REQ-010 dataD  input  8  operand D.
REQ-011 pwm_busy  input  _CH_NUM  per-channel busy from downstream PWM generators.
REQ-012 pwm_en  output  _CH_NUM  per-channel enable.
REQ-013 duty_num  output  8*_CH_NUM  active duty count; channel k occupies bits [8k+7:8k].
REQ-014 pulse_dessert  output  16*_CH_NUM  active gap count; channel k occupies [16k+15:16k].
REQ-015 pulse_num  output  8*_CH_NUM  active pulse count (0 = infinite).
REQ-016 pat  output  _PAT_WIDTH*_CH_NUM  active pattern.
REQ-017 cmd_ack  output  1  one-cycle strobe when a command completes successfully.
REQ-018 cmd_err  output  1  one-cycle strobe when a command is rejected.
REQ-019 err_code  output  2  cause of the last error: 0 = bad opcode, 1 = bad channel, 2 = commit timeout, 3 = overrun; held until the next error.

Function
REQ-020 The block SHALL keep a shadow set and an active set of duty, dessert, num and PAT per channel; only the active set drives outputs.
REQ-021 FSM states SHALL be IDLE, DECODE, WAIT_IDLE and APPLY.
REQ-022 In IDLE, recv_done SHALL latch dataA–dataD and move to DECODE on the next edge; fields are not sampled in any other state.
REQ-023 In DECODE, a channel index >= _CH_NUM SHALL pulse cmd_err with err_code=1 and return to IDLE, with no register change.
REQ-024 Opcode 0x1 (TIMING) SHALL write shadow duty=dataD, dessert=dataB, num=dataC[7:0]; dataC[15:8] is ignored.
REQ-025 Opcode 0x2 (PATTERN) SHALL write shadow PAT=dataB[_PAT_WIDTH-1:0], zero-extended if _PAT_WIDTH>16.
REQ-026 Opcode 0x3 (ENABLE) SHALL set pwm_en[ch]=1, and opcode 0x4 (DISABLE) SHALL clear it.
REQ-027 Opcodes 0x1–0x4 SHALL complete in DECODE: the register is updated on the edge that leaves DECODE, and cmd_ack is high in the following cycle (IDLE).
REQ-028 Opcode 0x5 (COMMIT) SHALL go to APPLY if pwm_busy[ch]=0, and otherwise to WAIT_IDLE.
REQ-029 WAIT_IDLE SHALL count cycles from 0; pwm_busy[ch]=0 moves to APPLY; reaching _WAIT_MAX-1 without idle pulses cmd_err with err_code=2 and returns to IDLE with the active set unchanged.
REQ-030 APPLY SHALL copy shadow to active for ch in one cycle, force pwm_en[ch]=0 for that cycle, restore pwm_en[ch] to its prior value next cycle, pulse cmd_ack and return to IDLE.
REQ-031 Any other opcode SHALL pulse cmd_err with err_code=0 and return to IDLE.
REQ-032 A recv_done arriving outside IDLE SHALL be dropped and pulse cmd_err with err_code=3 in the cycle after it, without disturbing the command in progress.
REQ-033 If an overrun error coincides with a completion (ack or err) of the current command, the block SHALL report the current command's result in that cycle and the overrun in the next cycle.
REQ-034 Channels other than the addressed one SHALL never change.
REQ-035 cmd_ack and cmd_err SHALL never be high in the same cycle.

Reset
REQ-036 Asserting rst_n low SHALL immediately clear all shadow and active registers, pwm_en, cmd_ack, cmd_err, err_code and the wait counter to 0, and force the FSM to IDLE, including mid-WAIT_IDLE or mid-APPLY.
REQ-037 The first recv_done accepted after rst_n deasserts SHALL be the first one sampled in IDLE.

Verification
REQ-038 Send TIMING to ch2 (dataA=0x12, dataD=0x32, dataB=0x0032, dataC=0x0002), then COMMIT (dataA=0x52) with pwm_busy=0 -> duty_num[23:16]=0x32, pulse_dessert[47:32]=0x0032, pulse_num[23:16]=0x02; cmd_ack twice; pwm_en[2] low for exactly one cycle only if it was previously set.
REQ-039 Send COMMIT to ch0 with pwm_busy[0]=1, then release busy after 10 cycles -> active set loads 1 cycle after busy falls; there is no error.
REQ-040 Send COMMIT with busy held high and _WAIT_MAX=20 -> cmd_err with err_code=2 on cycle 20; active set unchanged.
REQ-041 Send dataA=0x90 -> err_code=0; with _CH_NUM=4, send dataA=0x16 -> err_code=1; no register change in either case.
REQ-042 Send recv_done during WAIT_IDLE -> cmd_err with err_code=3 the next cycle; the pending commit still completes.
REQ-043 Pulse rst_n low during WAIT_IDLE -> all outputs are 0 asynchronously; the next command decodes normally.
